// File: rtl/adc_cfg_pkg.sv
// Shared types for the ADC configuration sequencer: state encoding, strobe bundle
// and a constant-evaluable clog2.
package adc_cfg_pkg;

    localparam int unsigned SCNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_INCR      = 3'd3,
        ST_END       = 3'd4,
        ST_NEXT_CHIP = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

    typedef struct packed {
        logic load;
        logic scken;
        logic shen;
        logic busy;
        logic done;
    } strobe_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned v;
        int unsigned r;
        v = (n > 1) ? n - 1 : 0;
        r = 0;
        while (v > 0) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter.
module tmr_vote #(
    parameter int unsigned W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/adc_config_seq.sv
// Streams ROM words ADR_FIRST..ADR_LAST into each of NCHIP ADCs in turn, with
// abort, busy, and optional triplicated state voted back into a single view.
module adc_config_seq
    import adc_cfg_pkg::*;
#(
    parameter int unsigned   NCHIP     = 1,
    parameter int unsigned   AW        = 5,
    parameter logic [AW-1:0] ADR_FIRST = '0,
    parameter logic [AW-1:0] ADR_LAST  = AW'(16),
    parameter int unsigned   SHIFT_LEN = 46,
    parameter bit            TMR       = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             INIT,
    input  logic             ABORT,
    output logic [AW-1:0]    ADR,
    output logic [((NCHIP > 1) ? clog2(NCHIP) : 1)-1:0] CHIP,
    output logic [NCHIP-1:0] CS_N,
    output logic             LOAD,
    output logic             SCKEN,
    output logic             SHEN,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned CW = (NCHIP > 1) ? clog2(NCHIP) : 1;
    localparam int unsigned SW = $bits(strobe_t);

    logic [2:0]        state1_q, state2_q, state3_q, state_v;
    logic [AW-1:0]     adr1_q, adr2_q, adr3_q, adr_v;
    logic [CW-1:0]     chip1_q, chip2_q, chip3_q, chip_v;
    logic [SCNT_W-1:0] scntr1_q, scntr2_q, scntr3_q, scntr_v;
    logic [NCHIP-1:0]  csn1_q, csn2_q, csn3_q, csn_v;
    strobe_t           strb1_q, strb2_q, strb3_q, strb_v;

    state_e            state_d;
    logic [AW-1:0]     adr_d;
    logic [CW-1:0]     chip_d;
    logic [SCNT_W-1:0] scntr_d;
    logic [NCHIP-1:0]  csn_d;
    strobe_t           strb_d;
    logic              cs_sel;

    // Every copy is read only through its voter, so a single upset never propagates.
    tmr_vote #(.W(3))      u_vote_state (.a(state1_q), .b(state2_q), .c(state3_q), .y(state_v));
    tmr_vote #(.W(AW))     u_vote_adr   (.a(adr1_q),   .b(adr2_q),   .c(adr3_q),   .y(adr_v));
    tmr_vote #(.W(CW))     u_vote_chip  (.a(chip1_q),  .b(chip2_q),  .c(chip3_q),  .y(chip_v));
    tmr_vote #(.W(SCNT_W)) u_vote_scntr (.a(scntr1_q), .b(scntr2_q), .c(scntr3_q), .y(scntr_v));
    tmr_vote #(.W(NCHIP))  u_vote_csn   (.a(csn1_q),   .b(csn2_q),   .c(csn3_q),   .y(csn_v));
    tmr_vote #(.W(SW))     u_vote_strb  (.a(strb1_q),  .b(strb2_q),  .c(strb3_q),  .y(strb_v));

    // Next state, counters, then outputs decoded from the next state.
    always_comb begin
        state_d = ST_IDLE;
        adr_d   = adr_v;
        chip_d  = chip_v;
        scntr_d = '0;
        strb_d  = '0;
        csn_d   = '1;
        cs_sel  = 1'b0;

        case (state_v)
            ST_IDLE: begin
                state_d = INIT ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (scntr_v == SCNT_W'(SHIFT_LEN - 1)) begin
                    state_d = (adr_v == ADR_LAST) ? ST_END : ST_INCR;
                end else begin
                    state_d = ST_SHIFT;
                    scntr_d = scntr_v + SCNT_W'(1);
                end
            end
            ST_INCR: begin
                state_d = ST_LOAD;
                adr_d   = adr_v + AW'(1);
            end
            ST_END: begin
                state_d = (chip_v != CW'(NCHIP - 1)) ? ST_NEXT_CHIP : ST_DONE;
            end
            ST_NEXT_CHIP: begin
                state_d = ST_LOAD;
                chip_d  = chip_v + CW'(1);
                adr_d   = ADR_FIRST;
            end
            ST_DONE: begin
                state_d = INIT ? ST_DONE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (ABORT) begin
            state_d = ST_IDLE;
        end

        // IDLE always carries reset values, so abort in IDLE changes nothing.
        if (state_d == ST_IDLE) begin
            adr_d   = ADR_FIRST;
            chip_d  = '0;
            scntr_d = '0;
        end

        case (state_d)
            ST_LOAD: begin
                strb_d.load  = 1'b1;
                strb_d.scken = 1'b1;
                strb_d.busy  = 1'b1;
                cs_sel       = 1'b1;
            end
            ST_SHIFT: begin
                strb_d.scken = 1'b1;
                strb_d.shen  = 1'b1;
                strb_d.busy  = 1'b1;
                cs_sel       = 1'b1;
            end
            ST_INCR: begin
                strb_d.scken = 1'b1;
                strb_d.busy  = 1'b1;
                cs_sel       = 1'b1;
            end
            ST_END: begin
                strb_d.scken = 1'b1;
                strb_d.busy  = 1'b1;
            end
            ST_NEXT_CHIP: begin
                strb_d.busy  = 1'b1;
            end
            ST_DONE: begin
                strb_d.done  = 1'b1;
            end
            default: begin
            end
        endcase

        for (int unsigned i = 0; i < NCHIP; i++) begin
            csn_d[i] = !(cs_sel && (chip_d == CW'(i)));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin : p_copy1
        if (RST) begin
            state1_q <= ST_IDLE;
            adr1_q   <= ADR_FIRST;
            chip1_q  <= '0;
            scntr1_q <= '0;
            csn1_q   <= '1;
            strb1_q  <= '0;
        end else begin
            state1_q <= state_d;
            adr1_q   <= adr_d;
            chip1_q  <= chip_d;
            scntr1_q <= scntr_d;
            csn1_q   <= csn_d;
            strb1_q  <= strb_d;
        end
    end

    generate
        if (TMR) begin : g_tmr
            always_ff @(posedge CLK or posedge RST) begin : p_copy23
                if (RST) begin
                    state2_q <= ST_IDLE;
                    adr2_q   <= ADR_FIRST;
                    chip2_q  <= '0;
                    scntr2_q <= '0;
                    csn2_q   <= '1;
                    strb2_q  <= '0;
                    state3_q <= ST_IDLE;
                    adr3_q   <= ADR_FIRST;
                    chip3_q  <= '0;
                    scntr3_q <= '0;
                    csn3_q   <= '1;
                    strb3_q  <= '0;
                end else begin
                    state2_q <= state_d;
                    adr2_q   <= adr_d;
                    chip2_q  <= chip_d;
                    scntr2_q <= scntr_d;
                    csn2_q   <= csn_d;
                    strb2_q  <= strb_d;
                    state3_q <= state_d;
                    adr3_q   <= adr_d;
                    chip3_q  <= chip_d;
                    scntr3_q <= scntr_d;
                    csn3_q   <= csn_d;
                    strb3_q  <= strb_d;
                end
            end
        end else begin : g_single
            assign state2_q = state1_q;
            assign adr2_q   = adr1_q;
            assign chip2_q  = chip1_q;
            assign scntr2_q = scntr1_q;
            assign csn2_q   = csn1_q;
            assign strb2_q  = strb1_q;
            assign state3_q = state1_q;
            assign adr3_q   = adr1_q;
            assign chip3_q  = chip1_q;
            assign scntr3_q = scntr1_q;
            assign csn3_q   = csn1_q;
            assign strb3_q  = strb1_q;
        end
    endgenerate

    assign ADR   = adr_v;
    assign CHIP  = chip_v;
    assign CS_N  = csn_v;
    assign LOAD  = strb_v.load;
    assign SCKEN = strb_v.scken;
    assign SHEN  = strb_v.shen;
    assign BUSY  = strb_v.busy;
    assign DONE  = strb_v.done;

endmodule
